// File: rtl/tc_pl_cap_sched.sv
// Capture scheduler: enables per-channel capture controllers one at a time in
// ascending order over a latched mask, with a per-channel completion timeout.
module tc_pl_cap_sched #(
    parameter int N_CH = 4,
    parameter int TO_W = 16,
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] ch_mask,
    input  logic [TO_W-1:0] timeout,
    input  logic [N_CH-1:0] ch_cmpt,
    output logic [N_CH-1:0] ch_en,
    output logic [CW-1:0]   cur_ch,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] err_flags
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_FIN} state_t;

    state_t          state_reg;
    logic [N_CH-1:0] ch_en_reg;
    logic [N_CH-1:0] mask_reg;
    logic [N_CH-1:0] err_flags_reg;
    logic [CW-1:0]   cur_ch_reg;
    logic            busy_reg;
    logic            done_reg;
    logic [TO_W-1:0] timeout_reg;
    logic [TO_W-1:0] timer_reg;

    logic [N_CH-1:0] above_mask;
    logic [N_CH-1:0] first_oh;
    logic [N_CH-1:0] next_oh;
    logic            first_found;
    logic            next_found;
    logic [CW-1:0]   first_idx;
    logic [CW-1:0]   next_idx;
    logic            cmpt_hit;
    logic            timer_expire;

    // Latched channels strictly above the active one are the remaining work.
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            assign above_mask[gi] = mask_reg[gi] && (CW'(gi) > cur_ch_reg);
            assign first_oh[gi]   = first_found && (first_idx == CW'(gi));
            assign next_oh[gi]    = next_found && (next_idx == CW'(gi));
        end
    endgenerate

    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (ch_mask[k]) begin
                first_found = 1'b1;
                first_idx   = CW'(k);
            end
            if (above_mask[k]) begin
                next_found = 1'b1;
                next_idx   = CW'(k);
            end
        end
    end

    assign cmpt_hit     = |(ch_cmpt & ch_en_reg);
    // Expire on the cycle the timer would step from 1 to 0.
    assign timer_expire = (timeout_reg != '0) && (timer_reg <= TO_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ch_en_reg     <= '0;
            mask_reg      <= '0;
            err_flags_reg <= '0;
            cur_ch_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            timeout_reg   <= '0;
            timer_reg     <= '0;
        end else if (abort && (state_reg != S_IDLE)) begin
            state_reg <= S_IDLE;
            ch_en_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        mask_reg      <= ch_mask;
                        timeout_reg   <= timeout;
                        err_flags_reg <= '0;
                        if (first_found) begin
                            ch_en_reg  <= first_oh;
                            cur_ch_reg <= first_idx;
                            timer_reg  <= timeout;
                            busy_reg   <= 1'b1;
                            state_reg  <= S_RUN;
                        end else begin
                            done_reg  <= 1'b1;
                            state_reg <= S_FIN;
                        end
                    end
                end
                S_RUN: begin
                    if (cmpt_hit) begin
                        ch_en_reg <= '0;
                        state_reg <= S_GAP;
                    end else if (timer_expire) begin
                        err_flags_reg <= err_flags_reg | ch_en_reg;
                        ch_en_reg     <= '0;
                        timer_reg     <= '0;
                        state_reg     <= S_GAP;
                    end else if (timeout_reg != '0) begin
                        timer_reg <= timer_reg - TO_W'(1);
                    end
                end
                S_GAP: begin
                    if (next_found) begin
                        ch_en_reg  <= next_oh;
                        cur_ch_reg <= next_idx;
                        timer_reg  <= timeout_reg;
                        state_reg  <= S_RUN;
                    end else begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign ch_en     = ch_en_reg;
    assign cur_ch    = cur_ch_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err_flags = err_flags_reg;

endmodule

// File: tb/tb_tc_pl_cap_sched.sv
// Bench for tc_pl_cap_sched: directed scan table, abort sequence and random
// scans scored against a per-channel duration/latency model.
module tb_tc_pl_cap_sched;
    localparam int N_CH   = 4;
    localparam int TO_W   = 16;
    localparam int CW     = 2;
    localparam int BUDGET = 2000;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            abort;
    logic [N_CH-1:0] ch_mask;
    logic [TO_W-1:0] timeout;
    logic [N_CH-1:0] ch_cmpt;
    logic [N_CH-1:0] ch_en;
    logic [CW-1:0]   cur_ch;
    logic            busy;
    logic            done;
    logic [N_CH-1:0] err_flags;

    always #5 clk = ~clk;

    tc_pl_cap_sched #(.N_CH(N_CH), .TO_W(TO_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ch_mask   (ch_mask),
        .timeout   (timeout),
        .ch_cmpt   (ch_cmpt),
        .ch_en     (ch_en),
        .cur_ch    (cur_ch),
        .busy      (busy),
        .done      (done),
        .err_flags (err_flags)
    );

    typedef struct {
        logic [3:0]      mask;
        int              to;
        logic [3:0][7:0] dly;       // enable cycles until completion, 0 = never
        bit              perturb;
        logic [3:0][7:0] exp_dur;
        logic [3:0]      exp_err;
        int              exp_lat;
    } vec_t;

    vec_t  vecs[8];
    int    total = 0;
    int    bad   = 0;
    int    dly[4];
    string cur_name;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] q4(input int a0, input int a1, input int a2, input int a3);
        q4 = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    // Each masked channel in turn: enabled for min(completion delay, timeout)
    // cycles, then one gap cycle; done follows the last gap.
    function automatic void model(input logic [3:0] m, input int to,
                                  output logic [3:0][7:0] dur, output logic [3:0] err,
                                  output int lat);
        dur = '0;
        err = '0;
        lat = 1;
        for (int i = 0; i < 4; i++) begin
            int need;
            int d;
            need = (dly[i] == 0) ? (1 << 20) : dly[i];
            d    = need;
            if (m[i]) begin
                if (to != 0 && need > to) begin
                    d      = to;
                    err[i] = 1'b1;
                end
                dur[i] = 8'(d);
                lat   += d + 1;
            end
        end
    endfunction

    task automatic run_scan(input logic [3:0] m, input int to, input bit perturb,
                            input logic [3:0][7:0] exp_dur, input logic [3:0] exp_err,
                            input int exp_lat);
        int         cyc;
        int         lat;
        int         en_cnt[4];
        int         obs_dur[4];
        int         last_idx;
        int         idx;
        bit         have_prev;
        bit         got_done;
        bit         onehot_ok;
        bit         order_ok;
        bit         cur_ok;
        bit         proto_ok;
        logic [3:0] obs_set;
        logic [3:0] obs_err;
        logic [3:0] prev_en;
        for (int i = 0; i < 4; i++) begin
            en_cnt[i]  = 0;
            obs_dur[i] = 0;
        end
        lat = 0; last_idx = 0; idx = 0; have_prev = 0; got_done = 0;
        onehot_ok = 1; order_ok = 1; cur_ok = 1; proto_ok = 1;
        obs_set = '0; obs_err = '0; prev_en = '0;
        start   = 1'b1;
        ch_mask = m;
        timeout = TO_W'(to);
        ch_cmpt = '0;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (!got_done && cyc <= BUDGET) begin
            if ($countones(ch_en) > 1) onehot_ok = 0;
            if (done) begin
                got_done = 1;
                lat      = cyc;
                obs_err  = err_flags;
                if (busy || ch_en != 0) proto_ok = 0;
            end else begin
                if (!busy) proto_ok = 0;
                if (ch_en != 0) begin
                    for (int i = 0; i < 4; i++) if (ch_en[i]) idx = i;
                    if (int'(cur_ch) != idx) cur_ok = 0;
                    if (ch_en != prev_en) begin
                        if (obs_set[idx] || (have_prev && idx <= last_idx)) order_ok = 0;
                        obs_set[idx] = 1'b1;
                        last_idx     = idx;
                        have_prev    = 1;
                    end
                    obs_dur[idx]++;
                end
            end
            prev_en = ch_en;
            for (int i = 0; i < 4; i++) begin
                if (ch_en[i]) begin
                    en_cnt[i]++;
                    ch_cmpt[i] = (en_cnt[i] == dly[i]);
                end else begin
                    ch_cmpt[i] = perturb ? ($urandom_range(0, 3) == 0) : 1'b0;
                end
            end
            if (perturb) begin
                ch_mask = 4'($urandom);
                timeout = TO_W'($urandom_range(0, 20));
                start   = busy && ($urandom_range(0, 4) == 0);
            end
            if (!got_done) begin
                tick();
                cyc++;
            end
        end
        start   = 1'b0;
        ch_cmpt = '0;
        ch_mask = '0;
        timeout = '0;
        check({cur_name, " done_seen"}, int'(got_done), 1);
        if (!got_done) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end else begin
            check({cur_name, " latency"}, lat, exp_lat);
            check({cur_name, " err_flags"}, int'(obs_err), int'(exp_err));
            check({cur_name, " enabled_set"}, int'(obs_set), int'(m));
            for (int i = 0; i < 4; i++)
                check($sformatf("%s dur_ch%0d", cur_name, i), obs_dur[i], int'(exp_dur[i]));
            check({cur_name, " onehot"}, int'(onehot_ok), 1);
            check({cur_name, " order"}, int'(order_ok), 1);
            check({cur_name, " cur_ch"}, int'(cur_ok), 1);
            check({cur_name, " busy_done"}, int'(proto_ok), 1);
            tick();
            check({cur_name, " idle_after"}, int'({done, busy, ch_en}), 0);
        end
        $display("scan %s mask=%b to=%0d lat=%0d exp_lat=%0d err=%b", cur_name, m, to, lat,
                 exp_lat, obs_err);
    endtask

    initial begin
        logic [3:0][7:0] e_dur;
        logic [3:0]      e_err;
        logic [3:0]      r_mask;
        int              e_lat;
        int              r_to;
        int              n;
        bit              saw;

        vecs[0] = '{mask: 4'b0000, to: 0, dly: q4(0, 0, 0, 0), perturb: 0,
                    exp_dur: q4(0, 0, 0, 0), exp_err: 4'b0000, exp_lat: 1};
        vecs[1] = '{mask: 4'b1011, to: 0, dly: q4(5, 5, 0, 5), perturb: 0,
                    exp_dur: q4(5, 5, 0, 5), exp_err: 4'b0000, exp_lat: 19};
        vecs[2] = '{mask: 4'b0110, to: 8, dly: q4(0, 0, 3, 0), perturb: 0,
                    exp_dur: q4(0, 8, 3, 0), exp_err: 4'b0010, exp_lat: 14};
        vecs[3] = '{mask: 4'b0001, to: 4, dly: q4(4, 0, 0, 0), perturb: 0,
                    exp_dur: q4(4, 0, 0, 0), exp_err: 4'b0000, exp_lat: 6};
        vecs[4] = '{mask: 4'b0001, to: 4, dly: q4(5, 0, 0, 0), perturb: 0,
                    exp_dur: q4(4, 0, 0, 0), exp_err: 4'b0001, exp_lat: 6};
        vecs[5] = '{mask: 4'b1000, to: 1, dly: q4(0, 0, 0, 0), perturb: 0,
                    exp_dur: q4(0, 0, 0, 1), exp_err: 4'b1000, exp_lat: 3};
        vecs[6] = '{mask: 4'b1111, to: 3, dly: q4(1, 3, 0, 2), perturb: 1,
                    exp_dur: q4(1, 3, 3, 2), exp_err: 4'b0100, exp_lat: 14};
        vecs[7] = '{mask: 4'b0101, to: 0, dly: q4(2, 9, 7, 0), perturb: 1,
                    exp_dur: q4(2, 0, 7, 0), exp_err: 4'b0000, exp_lat: 12};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        ch_mask = '0; timeout = '0; ch_cmpt = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("reset ch_en", int'(ch_en), 0);
        check("reset cur_ch", int'(cur_ch), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset err_flags", int'(err_flags), 0);

        for (int v = 0; v < 8; v++) begin
            cur_name = $sformatf("vec%0d", v);
            for (int i = 0; i < 4; i++) dly[i] = int'(vecs[v].dly[i]);
            run_scan(vecs[v].mask, vecs[v].to, vecs[v].perturb, vecs[v].exp_dur,
                     vecs[v].exp_err, vecs[v].exp_lat);
        end

        // Abort mid-way through ch2 after ch1 has timed out.
        cur_name = "abort";
        start = 1'b1; ch_mask = 4'b0110; timeout = TO_W'(6);
        tick();
        start = 1'b0;
        n = 0;
        while (ch_en != 4'b0100 && n < 50) begin
            tick();
            n++;
        end
        check("abort reach_ch2", int'(ch_en), 4);
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort ch_en", int'(ch_en), 0);
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort err_flags_kept", int'(err_flags), 2);
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done || busy || ch_en != 0) saw = 1;
        end
        check("abort stays_idle", int'(saw), 0);
        $display("scan abort mask=0110 to=6 err=%b", err_flags);

        cur_name = "post_abort";
        dly = '{3, 0, 0, 0};
        run_scan(4'b0001, 0, 0, q4(3, 0, 0, 0), 4'b0000, 5);

        for (int r = 0; r < 40; r++) begin
            r_mask = 4'($urandom);
            r_to   = $urandom_range(0, 10);
            for (int i = 0; i < 4; i++) begin
                dly[i] = $urandom_range(0, 12);
                if (r_to == 0 && dly[i] == 0) dly[i] = $urandom_range(1, 12);
            end
            model(r_mask, r_to, e_dur, e_err, e_lat);
            cur_name = $sformatf("rnd%0d", r);
            run_scan(r_mask, r_to, bit'($urandom_range(0, 1)), e_dur, e_err, e_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
